mem_arbiter: RTL and testbench

- Shares the single main-memory block port between the I-cache (read-only block fills) and the D-cache (block fills and write-backs).
- Sits between both caches and main memory.
- Returns a per-requester busywait and read data to the caches.
- Alternates grants when both caches miss together, so neither pipeline stage (IF or MEM) starves.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory block port between the I-cache (read fills) and the
// D-cache (fills and write-backs), alternating grants when both miss together.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_WAIT   = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READDATA,
  output logic                  I_BUSYWAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
  output logic [DATA_WIDTH-1:0] D_READDATA,
  output logic                  D_BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [DATA_WIDTH-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic                  ERROR
);

  localparam int unsigned CntWidth = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIServe, StDServe, StDone} state_e;
  typedef enum logic {OwnI, OwnD} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_owner_q, last_owner_d;
  logic                  issued_q, issued_d;
  logic [CntWidth-1:0]   wait_cnt_q, wait_cnt_d;
  logic                  error_q, error_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  i_req, d_req, grant_d;
  logic [CntWidth-1:0]   wait_inc;

  assign i_req    = I_READ;
  assign d_req    = D_READ | D_WRITE;
  // On a tie the grant goes to whoever did not own the port last.
  assign grant_d  = d_req & (~i_req | (last_owner_q == OwnI));
  assign wait_inc = (wait_cnt_q == MaxCnt) ? wait_cnt_q : wait_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    issued_d     = issued_q;
    wait_cnt_d   = wait_cnt_q;
    error_d      = error_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          issued_d   = 1'b0;
          wait_cnt_d = '0;
          if (grant_d) begin
            owner_d      = OwnD;
            last_owner_d = OwnD;
            mem_addr_d   = D_ADDRESS;
            mem_wdata_d  = D_WRITEDATA;
            mem_write_d  = D_WRITE;
            mem_read_d   = ~D_WRITE;
            state_d      = StDServe;
          end else begin
            owner_d      = OwnI;
            last_owner_d = OwnI;
            mem_addr_d   = I_ADDRESS;
            mem_write_d  = 1'b0;
            mem_read_d   = 1'b1;
            state_d      = StIServe;
          end
        end
      end
      StIServe, StDServe: begin
        // The edge right after the grant only issues the strobe to memory.
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (!MEM_BUSYWAIT) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (owner_q == OwnI) i_rdata_d = MEM_READDATA;
            else                 d_rdata_d = MEM_READDATA;
          end
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == MaxCnt) error_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      owner_q      <= OwnI;
      last_owner_q <= OwnI;
      issued_q     <= 1'b0;
      wait_cnt_q   <= '0;
      error_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      issued_q     <= issued_d;
      wait_cnt_q   <= wait_cnt_d;
      error_q      <= error_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign I_BUSYWAIT    = I_READ & ~((state_q == StDone) && (owner_q == OwnI));
  assign D_BUSYWAIT    = (D_READ | D_WRITE) & ~((state_q == StDone) && (owner_q == OwnD));
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign I_READDATA    = i_rdata_q;
  assign D_READDATA    = d_rdata_q;
  assign ERROR         = error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model driving MEM_BUSYWAIT.
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         I_READ;
  logic [27:0]  I_ADDRESS;
  logic [127:0] I_READDATA;
  logic         I_BUSYWAIT;
  logic         D_READ;
  logic         D_WRITE;
  logic [27:0]  D_ADDRESS;
  logic [127:0] D_WRITEDATA;
  logic [127:0] D_READDATA;
  logic         D_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;
  logic         ERROR;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 0;
  int mem_cnt  = 0;

  localparam logic [127:0] PatA = {4{32'hA5A5A5A5}};
  localparam logic [127:0] PatB = {4{32'h1234_5678}};
  localparam logic [127:0] PatC = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] PatE = {4{32'h0F0F_F0F0}};
  localparam logic [127:0] PatF = {4{32'hCAFE_0001}};
  localparam logic [27:0]  IAddr = 28'h1234567;
  localparam logic [27:0]  DAddr = 28'h0ABCDEF;

  mem_arbiter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_READ       (I_READ),
    .I_ADDRESS    (I_ADDRESS),
    .I_READDATA   (I_READDATA),
    .I_BUSYWAIT   (I_BUSYWAIT),
    .D_READ       (D_READ),
    .D_WRITE      (D_WRITE),
    .D_ADDRESS    (D_ADDRESS),
    .D_WRITEDATA  (D_WRITEDATA),
    .D_READDATA   (D_READDATA),
    .D_BUSYWAIT   (D_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .ERROR        (ERROR)
  );

  always #5 CLK = ~CLK;

  // Memory stays busy for `lat` sampled edges after the issue edge.
  always @(posedge CLK) mem_cnt <= (MEM_READ | MEM_WRITE) ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt <= lat);

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  // Steps until the selected requester's busywait drops; reports steps taken and strobe activity.
  task automatic wait_done(input bit is_d, input int bound, output int steps,
                           output int strobe_cycles, output bit saw_read);
    steps = 0;
    strobe_cycles = 0;
    saw_read = 1'b0;
    for (int k = 0; k < bound; k++) begin
      step();
      steps++;
      if (MEM_READ) saw_read = 1'b1;
      if (is_d ? !D_BUSYWAIT : !I_BUSYWAIT) break;
      if (MEM_READ | MEM_WRITE) strobe_cycles++;
    end
  endtask

  int  steps, strobes;
  bit  saw_rd;
  int  grants[$];
  bit  prev;

  initial begin
    RESET = 1'b0; I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = IAddr; D_ADDRESS = DAddr; D_WRITEDATA = PatE; MEM_READDATA = PatA;
    do_reset();
    check_eq("rst_mem_read", 128'(MEM_READ), 128'(0));
    check_eq("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    check_eq("rst_mem_addr", 128'(MEM_ADDRESS), 128'(0));
    check_eq("rst_mem_wdata", MEM_WRITEDATA, 128'(0));
    check_eq("rst_i_rdata", I_READDATA, 128'(0));
    check_eq("rst_d_rdata", D_READDATA, 128'(0));
    check_eq("rst_error", 128'(ERROR), 128'(0));

    // I-only read with 4 busy cycles.
    lat = 4;
    I_READ = 1'b1;
    #1;
    check_eq("t1_i_busy_now", 128'(I_BUSYWAIT), 128'(1));
    wait_done(1'b0, 50, steps, strobes, saw_rd);
    check_eq("t1_latency", 128'(steps), 128'(7));
    check_eq("t1_read_cycles", 128'(strobes), 128'(6));
    check_eq("t1_mem_read_low", 128'(MEM_READ), 128'(0));
    check_eq("t1_i_rdata", I_READDATA, PatA);
    check_eq("t1_d_busy", 128'(D_BUSYWAIT), 128'(0));
    I_READ = 1'b0;
    step();
    check_eq("t1_i_rdata_hold", I_READDATA, PatA);

    // Simultaneous I read and D write after reset: D first, then alternation.
    do_reset();
    lat = 1;
    I_READ = 1'b1; D_WRITE = 1'b1; MEM_READDATA = PatF;
    step();
    check_eq("t2_first_write", 128'(MEM_WRITE), 128'(1));
    check_eq("t2_first_read", 128'(MEM_READ), 128'(0));
    check_eq("t2_first_addr", 128'(MEM_ADDRESS), 128'(DAddr));
    check_eq("t2_first_wdata", MEM_WRITEDATA, PatE);
    prev = 1'b1;
    grants.delete();
    for (int k = 0; k < 80 && grants.size() < 3; k++) begin
      step();
      if ((MEM_READ | MEM_WRITE) && !prev) begin
        grants.push_back(MEM_WRITE ? 1 : 0);
        check_eq("t2_grant_addr", 128'(MEM_ADDRESS), 128'(MEM_WRITE ? DAddr : IAddr));
      end
      prev = MEM_READ | MEM_WRITE;
    end
    check_eq("t2_grant_count", 128'(grants.size()), 128'(3));
    for (int k = 0; k < grants.size(); k++)
      check_eq("t2_alternate", 128'(grants[k]), 128'((k % 2 == 0) ? 0 : 1));
    check_eq("t2_i_rdata", I_READDATA, PatF);
    I_READ = 1'b0; D_WRITE = 1'b0;
    repeat (8) step();

    // D_READ and D_WRITE together: write wins, D_READDATA untouched.
    do_reset();
    lat = 0;
    MEM_READDATA = PatB; D_ADDRESS = 28'h0000020; D_READ = 1'b1;
    wait_done(1'b1, 50, steps, strobes, saw_rd);
    check_eq("t3_min_latency", 128'(steps), 128'(3));
    check_eq("t3_d_rdata", D_READDATA, PatB);
    D_READ = 1'b0;
    step();
    MEM_READDATA = PatC; D_ADDRESS = 28'h0000010; D_WRITEDATA = PatE;
    D_READ = 1'b1; D_WRITE = 1'b1;
    step();
    check_eq("t3_write", 128'(MEM_WRITE), 128'(1));
    check_eq("t3_no_read", 128'(MEM_READ), 128'(0));
    check_eq("t3_addr", 128'(MEM_ADDRESS), 128'(28'h0000010));
    check_eq("t3_wdata", MEM_WRITEDATA, PatE);
    wait_done(1'b1, 50, steps, strobes, saw_rd);
    check_eq("t3_wr_steps", 128'(steps), 128'(2));
    check_eq("t3_saw_read", 128'(saw_rd), 128'(0));
    check_eq("t3_d_rdata_kept", D_READDATA, PatB);
    D_READ = 1'b0; D_WRITE = 1'b0;
    step();

    // I_READ withdrawn two cycles into service.
    lat = 5;
    MEM_READDATA = PatC; D_ADDRESS = DAddr;
    I_READ = 1'b1;
    step();
    step();
    step();
    I_READ = 1'b0; D_READ = 1'b1;
    #1;
    check_eq("t4_i_busy_dropped", 128'(I_BUSYWAIT), 128'(0));
    steps = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      steps++;
      if (!MEM_READ) break;
      check_eq("t4_addr_held", 128'(MEM_ADDRESS), 128'(IAddr));
    end
    check_eq("t4_drain_steps", 128'(steps), 128'(5));
    check_eq("t4_i_rdata", I_READDATA, PatC);
    check_eq("t4_i_busy", 128'(I_BUSYWAIT), 128'(0));
    check_eq("t4_d_busy", 128'(D_BUSYWAIT), 128'(1));
    step();
    check_eq("t4_no_grant_in_done", 128'(MEM_READ), 128'(0));
    step();
    check_eq("t4_d_grant", 128'(MEM_READ), 128'(1));
    check_eq("t4_d_addr", 128'(MEM_ADDRESS), 128'(DAddr));
    wait_done(1'b1, 50, steps, strobes, saw_rd);
    check_eq("t4_d_steps", 128'(steps), 128'(7));
    check_eq("t4_d_rdata", D_READDATA, PatC);
    D_READ = 1'b0;
    step();

    // Reset during D service.
    lat = 10;
    D_READ = 1'b1;
    step();
    step();
    step();
    RESET = 1'b1;
    step();
    check_eq("t5_mem_read", 128'(MEM_READ), 128'(0));
    check_eq("t5_mem_write", 128'(MEM_WRITE), 128'(0));
    check_eq("t5_i_rdata", I_READDATA, 128'(0));
    check_eq("t5_d_rdata", D_READDATA, 128'(0));
    check_eq("t5_error", 128'(ERROR), 128'(0));
    RESET = 1'b0; D_READ = 1'b0;
    step();
    check_eq("t5_idle", 128'(MEM_READ), 128'(0));
    I_READ = 1'b1;
    step();
    check_eq("t5_grant_i", 128'(MEM_READ), 128'(1));
    check_eq("t5_grant_addr", 128'(MEM_ADDRESS), 128'(IAddr));
    wait_done(1'b0, 50, steps, strobes, saw_rd);
    check_eq("t5_done_steps", 128'(steps), 128'(12));
    I_READ = 1'b0;
    step();

    // Memory timeout: ERROR at the 255th busy edge, sticky until reset.
    do_reset();
    lat = 300;
    MEM_READDATA = PatB;
    I_READ = 1'b1;
    step();
    step();
    repeat (254) step();
    check_eq("t6_error_254", 128'(ERROR), 128'(0));
    step();
    check_eq("t6_error_255", 128'(ERROR), 128'(1));
    wait_done(1'b0, 100, steps, strobes, saw_rd);
    check_eq("t6_done_steps", 128'(steps), 128'(46));
    check_eq("t6_i_rdata", I_READDATA, PatB);
    check_eq("t6_error_done", 128'(ERROR), 128'(1));
    I_READ = 1'b0;
    step();
    step();
    check_eq("t6_error_sticky", 128'(ERROR), 128'(1));
    do_reset();
    check_eq("t6_error_cleared", 128'(ERROR), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
